// File: rtl/crc_pkg.sv
// crc_pkg: shared CRC-8 constants and one-hot FSM encoding for crc_check_unit.
package crc_pkg;
  localparam int CRC_W = 8;
  localparam logic [CRC_W-1:0] POLY = 8'h07;
  localparam logic [CRC_W-1:0] INIT = 8'h00;
  localparam int S_IDLE = 0;
  localparam int S_SHIFT = 1;
  localparam int S_DONE = 2;
  localparam logic [2:0] ST_IDLE = 3'b001;
  localparam logic [2:0] ST_SHIFT = 3'b010;
  localparam logic [2:0] ST_DONE = 3'b100;
endpackage

// File: rtl/crc8_step.sv
// crc8_step: combinational single-bit LFSR update, MSB-first, implicit top term.
module crc8_step
  import crc_pkg::*;
#(
  parameter int W = CRC_W,
  parameter logic [W-1:0] P = POLY
) (
  input  logic [W-1:0] crc_in,
  input  logic         bit_in,
  output logic [W-1:0] crc_out
);
  logic fb;
  assign fb = crc_in[W-1] ^ bit_in;
  assign crc_out = {crc_in[W-2:0], 1'b0} ^ (fb ? P : '0);
endmodule

// File: rtl/crc_check_unit.sv
// crc_check_unit: bit-serial CRC-8 generate/check engine with done/match handshake.
module crc_check_unit
  import crc_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [DATA_W-1:0] data_in,
  input  logic [CRC_W-1:0]  crc_ref,
  output logic              busy,
  output logic              done,
  output logic              match,
  output logic [CRC_W-1:0]  crc_out
);
  logic [2:0] state_q, state_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [CRC_W-1:0] crc_q, crc_d, ref_q, ref_d, out_q, out_d, nxt;
  logic [CW-1:0] cnt_q, cnt_d;
  logic mode_q, mode_d, match_q, match_d;
  crc8_step #(.W(CRC_W), .P(POLY)) u_step (.crc_in(crc_q), .bit_in(sh_q[DATA_W-1]), .crc_out(nxt));
  always_comb begin
    state_d = state_q;
    sh_d = sh_q;
    crc_d = crc_q;
    cnt_d = cnt_q;
    mode_d = mode_q;
    ref_d = ref_q;
    out_d = out_q;
    match_d = match_q;
    if (state_q[S_IDLE]) begin
      if (start) begin
        sh_d = data_in;
        crc_d = INIT;
        cnt_d = '0;
        mode_d = mode;
        ref_d = crc_ref;
        state_d = ST_SHIFT;
      end
    end else if (state_q[S_SHIFT]) begin
      sh_d = sh_q << 1;
      crc_d = nxt;
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == CW'(DATA_W - 1)) begin
        state_d = ST_DONE;
        out_d = nxt;
        match_d = mode_q && (nxt == ref_q);
      end
    end else begin
      state_d = ST_IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      sh_q <= '0;
      crc_q <= '0;
      cnt_q <= '0;
      mode_q <= 1'b0;
      ref_q <= '0;
      out_q <= '0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q <= sh_d;
      crc_q <= crc_d;
      cnt_q <= cnt_d;
      mode_q <= mode_d;
      ref_q <= ref_d;
      out_q <= out_d;
      match_q <= match_d;
    end
  end
  assign busy = state_q[S_SHIFT] | state_q[S_DONE];
  assign done = state_q[S_DONE];
  assign match = match_q;
  assign crc_out = out_q;
endmodule

// File: tb/tb_crc_check_unit.sv
// tb_crc_check_unit: randomized scoreboard bench using a polynomial-division CRC model.
module tb_crc_check_unit;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic mode = 1'b0;
  logic [7:0] data_in = '0;
  logic [7:0] crc_ref = '0;
  logic busy, done, match;
  logic [7:0] crc_out;

  typedef struct {
    int due;
    logic [7:0] crc;
    logic m;
  } exp_t;

  exp_t q[$];
  int cyc = 0;
  int rem = 0;
  bit rst_seen = 1'b0;
  logic [7:0] held_crc = '0;
  logic held_m = 1'b0;
  int vecs = 0;
  int errs = 0;

  crc_check_unit dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .data_in(data_in),
    .crc_ref(crc_ref), .busy(busy), .done(done), .match(match), .crc_out(crc_out)
  );

  always #5 clk = ~clk;

  // Remainder of data*x^8 divided by x^8+x^2+x+1 over GF(2); seed is zero.
  function automatic logic [7:0] crc_div(input logic [7:0] d);
    logic [15:0] r;
    r = {d, 8'h00};
    for (int i = 15; i >= 8; i--)
      if (r[i]) r = r ^ (16'h0107 << (i - 8));
    return r[7:0];
  endfunction

  task automatic check(input string name, input int act, input int req);
    vecs++;
    if (act != req) begin
      errs++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (!reset) begin
      q.delete();
      rem = 0;
      rst_seen = 1'b1;
      held_crc = '0;
      held_m = 1'b0;
    end else begin
      rst_seen = 1'b0;
      if (rem == 0 && start) begin
        q.push_back('{due: cyc + 8, crc: crc_div(data_in), m: mode && (crc_div(data_in) == crc_ref)});
        rem = 9;
      end else if (rem > 0) begin
        rem--;
      end
    end
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      if (rst_seen) begin
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_match", match, 0);
        check("rst_crc", crc_out, 0);
      end else begin
        check("busy", busy, rem > 0);
        if (done) begin
          if (q.size() == 0) begin
            check("unexpected_done", 1, 0);
          end else begin
            exp_t e;
            e = q.pop_front();
            check("done_cycle", cyc, e.due);
            check("crc_out", crc_out, e.crc);
            check("match", match, e.m);
            held_crc = e.crc;
            held_m = e.m;
          end
        end else begin
          if (q.size() > 0 && q[0].due <= cyc) begin
            check("missing_done", 0, 1);
            void'(q.pop_front());
          end
          check("crc_hold", crc_out, held_crc);
          check("match_hold", match, held_m);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input logic m, input logic [7:0] d, input logic [7:0] r);
    start = 1'b1;
    mode = m;
    data_in = d;
    crc_ref = r;
    step(1);
    start = 1'b0;
    mode = ~m;
    data_in = ~d;
    crc_ref = ~r;
  endtask

  initial begin
    step(3);
    reset = 1'b1;
    step(3);
    issue(1'b0, 8'h01, 8'h00); step(10);
    issue(1'b0, 8'h80, 8'h00); step(10);
    issue(1'b0, 8'hFF, 8'h00); step(10);
    issue(1'b1, 8'h80, 8'h89); step(10);
    issue(1'b1, 8'h80, 8'h88); step(10);
    issue(1'b0, 8'h5A, 8'h00); step(2);
    issue(1'b1, 8'hC3, 8'h12); step(10);
    issue(1'b0, 8'hA5, 8'h00); step(3);
    reset = 1'b0; step(1); reset = 1'b1; step(2);
    issue(1'b0, 8'h01, 8'h00); step(10);
    start = 1'b1; mode = 1'b0; data_in = 8'h00; crc_ref = 8'h00;
    step(40);
    start = 1'b0;
    step(12);
    for (int i = 0; i < 400; i++) begin
      logic [7:0] d;
      d = 8'($urandom);
      start = ($urandom_range(0, 2) == 0);
      mode = 1'($urandom);
      data_in = d;
      crc_ref = $urandom_range(0, 1) ? crc_div(d) : 8'($urandom);
      reset = ($urandom_range(0, 99) != 0);
      step(1);
    end
    start = 1'b0;
    reset = 1'b1;
    step(12);
    check("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
